// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg: shared state type, HD44780 command constants and init ROM for lcd_ctrl
package lcd_ctrl_pkg;
  typedef enum logic [2:0] {PWR_WAIT, SETUP, EN_HIGH, POST_WAIT, IDLE} state_t;
  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON = 8'h0C;
  localparam logic [7:0] CLEAR = 8'h01;
  localparam logic [7:0] ENTRY_INC = 8'h06;
  localparam int INIT_LEN = 5;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{FUNC_SET_8B2L, FUNC_SET_8B2L, DISP_ON, CLEAR, ENTRY_INC};
  // clear (01) and return-home (02/03) need the long settle time
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && data[7:2] == 6'd0 && data != 8'd0;
  endfunction
endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter; done_o pulses for one cycle in the last counted cycle
module lcd_delay_cnt #(
  parameter int W = 22
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         done_o
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else if (load_i) cnt <= value_i;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign done_o = cnt == W'(1);
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 sequencer; runs power-on init, then issues host writes with timed RS/EN/DATA
module lcd_ctrl
  import lcd_ctrl_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 5,
  parameter int unsigned EN_PULSE_CYC = 25,
  parameter int unsigned CMD_WAIT_CYC = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000,
  parameter int unsigned PWRON_WAIT_CYC = 2000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);
  localparam int unsigned S = SETUP_CYC == 0 ? 1 : SETUP_CYC;
  localparam int unsigned P = EN_PULSE_CYC == 0 ? 1 : EN_PULSE_CYC;
  localparam int unsigned M = CMD_WAIT_CYC == 0 ? 1 : CMD_WAIT_CYC;
  localparam int unsigned C = CLEAR_WAIT_CYC == 0 ? 1 : CLEAR_WAIT_CYC;
  localparam int unsigned PW = PWRON_WAIT_CYC == 0 ? 1 : PWRON_WAIT_CYC;
  localparam int unsigned M1 = S > P ? S : P;
  localparam int unsigned M2 = M1 > M ? M1 : M;
  localparam int unsigned M3 = M2 > C ? M2 : C;
  localparam int unsigned MX = M3 > PW ? M3 : PW;
  localparam int CW = $clog2(MX) + 1;
  state_t state;
  logic [2:0] idx;
  logic load, done, accept;
  logic [CW-1:0] value;
  assign lcd_rw_o = 1'b0;
  assign req_ready_o = state == IDLE;
  assign busy_o = state != IDLE;
  assign accept = req_valid_i && state == IDLE;
  // every state exit reloads the counter; the very first PWR_WAIT cycle arms the power-on wait
  always_comb begin
    load = accept || done || (state == PWR_WAIT && !lcd_on_o);
    value = state == PWR_WAIT ? (lcd_on_o ? CW'(S) : CW'(PW))
          : state == SETUP ? CW'(P)
          : state == EN_HIGH ? (is_long_cmd(lcd_rs_o, lcd_data_o) ? CW'(C) : CW'(M))
          : CW'(S);
  end
  lcd_delay_cnt #(.W(CW)) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .load_i(load),
    .value_i(value),
    .done_o(done)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= PWR_WAIT;
      idx <= '0;
      init_done_o <= 1'b0;
      lcd_on_o <= 1'b0;
      lcd_en_o <= 1'b0;
      lcd_rs_o <= 1'b0;
      lcd_data_o <= 8'h00;
    end else begin
      lcd_on_o <= 1'b1;
      case (state)
        PWR_WAIT: if (done) begin
          state <= SETUP;
          lcd_rs_o <= 1'b0;
          lcd_data_o <= INIT_ROM[0];
        end
        SETUP: if (done) begin
          state <= EN_HIGH;
          lcd_en_o <= 1'b1;
        end
        EN_HIGH: if (done) begin
          state <= POST_WAIT;
          lcd_en_o <= 1'b0;
        end
        POST_WAIT: if (done) begin
          if (!init_done_o && idx != 3'(INIT_LEN - 1)) begin
            idx <= idx + 3'd1;
            lcd_data_o <= INIT_ROM[idx + 3'd1];
            state <= SETUP;
          end else begin
            init_done_o <= 1'b1;
            state <= IDLE;
          end
        end
        IDLE: if (req_valid_i) begin
          state <= SETUP;
          lcd_rs_o <= req_rs_i;
          lcd_data_o <= req_data_i;
        end
        default: state <= PWR_WAIT;
      endcase
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed stimulus with an expected-pulse queue checked by an EN-edge monitor
module tb_lcd_ctrl;
  localparam int S = 2, P = 3, M = 10, C = 40, PW = 50;
  typedef struct {logic rs; logic [7:0] d; int gap;} exp_t;
  logic clk = 0, rst = 1, req_valid = 0, req_rs = 0;
  logic [7:0] req_data = 0;
  logic req_ready_o, busy_o, init_done_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o;
  logic [7:0] lcd_data_o;
  int tests = 0, fails = 0, rw_bad = 0;
  exp_t q[$];
  exp_t cur;
  int phase = 0, width = 0, gap = 0;
  bit stable, en_q = 0;
  lcd_ctrl #(.SETUP_CYC(S), .EN_PULSE_CYC(P), .CMD_WAIT_CYC(M), .CLEAR_WAIT_CYC(C), .PWRON_WAIT_CYC(PW)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
    .req_rs_i(req_rs), .req_data_i(req_data), .busy_o(busy_o), .init_done_o(init_done_o),
    .lcd_on_o(lcd_on_o), .lcd_en_o(lcd_en_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o),
    .lcd_data_o(lcd_data_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask
  always @(negedge clk) if (lcd_rw_o !== 1'b0) rw_bad++;
  // gap = low samples after a pulse until the next EN rise or until ready returns
  always @(negedge clk) begin
    if (rst) begin
      phase = 0;
      en_q = 0;
    end else begin
      if (lcd_en_o) begin
        if (!en_q) begin
          if (phase == 2) chk("gap", gap, cur.gap);
          if (q.size() == 0) chk("extra_pulse", 1, 0);
          else begin
            cur = q.pop_front();
            chk("rs", lcd_rs_o, cur.rs);
            chk("data", lcd_data_o, cur.d);
          end
          width = 0;
          stable = 1;
          phase = 1;
        end
        width++;
        if (lcd_rs_o !== cur.rs || lcd_data_o !== cur.d) stable = 0;
      end else begin
        if (en_q) begin
          chk("width", width, P);
          chk("hold", stable, 1);
          phase = 2;
          gap = 0;
        end
        if (phase == 2) begin
          if (req_ready_o) begin
            chk("gap", gap, cur.gap);
            phase = 0;
          end else gap++;
        end
      end
      en_q = lcd_en_o;
    end
  end
  task automatic wait_ready(input string nm);
    int t = 0;
    while (!req_ready_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready_o) chk({nm, "_timeout"}, 0, 1);
  endtask
  task automatic send(input logic rs, input logic [7:0] d, input int g);
    int n = 0;
    q.push_back('{rs, d, g});
    req_rs = rs;
    req_data = d;
    req_valid = 1;
    wait_ready("acc");
    @(negedge clk);
    req_valid = 0;
    chk("rdy_drop", req_ready_o, 0);
    while (!lcd_en_o && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("lat", n, S);
  endtask
  // PWR_WAIT counts from the edge that raises lcd_on_o, then SETUP precedes the first EN
  task automatic power_up(input bit with_req);
    logic [7:0] ib [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int ig [5] = '{M + S, M + S, M + S, C + S, M};
    int n = 0;
    for (int i = 0; i < 5; i++) q.push_back('{1'b0, ib[i], ig[i]});
    if (with_req) q.push_back('{1'b1, 8'h55, M});
    #2 rst = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("on_after_rst", lcd_on_o, 1);
        chk("ready_pwr", req_ready_o, 0);
        chk("init_done_pwr", init_done_o, 0);
        if (with_req) begin
          req_rs = 1;
          req_data = 8'h55;
          req_valid = 1;
        end
      end
    end while (!lcd_en_o && n < 1000);
    chk("pwr_wait", n, PW + S + 1);
  endtask
  initial begin
    logic [7:0] burst [3] = '{8'h41, 8'h42, 8'h43};
    rst = 1;
    @(negedge clk);
    #1;
    chk("rst_on", lcd_on_o, 0);
    chk("rst_en", lcd_en_o, 0);
    chk("rst_rs", lcd_rs_o, 0);
    chk("rst_data", lcd_data_o, 0);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_init_done", init_done_o, 0);
    chk("rst_busy", busy_o, 1);
    @(negedge clk);
    power_up(0);
    wait_ready("init");
    chk("init_done", init_done_o, 1);
    chk("busy_idle", busy_o, 0);
    send(1, 8'h41, M);
    send(0, 8'h01, C);
    send(0, 8'h02, C);
    send(0, 8'h80, M);
    send(1, 8'h01, M);
    wait_ready("pre_burst");
    req_valid = 1;
    req_rs = 1;
    for (int k = 0; k < 3; k++) q.push_back('{1'b1, burst[k], M});
    for (int k = 0; k < 3; k++) begin
      req_data = burst[k];
      wait_ready("burst");
      @(negedge clk);
      chk("burst_rdy_1cyc", req_ready_o, 0);
    end
    req_valid = 0;
    wait_ready("post_burst");
    q.push_back('{1'b1, 8'h5A, 0});
    req_rs = 1;
    req_data = 8'h5A;
    req_valid = 1;
    wait_ready("acc6");
    @(negedge clk);
    req_valid = 0;
    for (int n = 0; n < 20 && !lcd_en_o; n++) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_en", lcd_en_o, 0);
    chk("async_on", lcd_on_o, 0);
    chk("async_data", lcd_data_o, 0);
    chk("async_rs", lcd_rs_o, 0);
    chk("async_busy", busy_o, 1);
    repeat (2) @(negedge clk);
    power_up(1);
    wait_ready("held_req");
    @(negedge clk);
    req_valid = 0;
    chk("held_rdy_drop", req_ready_o, 0);
    chk("init_done_again", init_done_o, 1);
    wait_ready("held_done");
    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("rw_zero", rw_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
